ct_lsu_dcache_dirty_array_pcfg: RTL
===================================

Name: ct_lsu_dcache_dirty_array_pcfg

Overview:
Parametrised dcache dirty-bit store: a DEPTH x WIDTH single-port array with a bit-masked write, a registered read and a read-valid strobe. Adds a hardware sweep that zeroes every entry after reset and on a flush request, with busy/done handshakes. Sits under the LSU dcache control in place of a fixed-size dirty SRAM wrapper. Storage is a flop/RAM behavioural array; there is no macro selection by define.

Parameters:
WIDTH, 7, dirty/state bits per index (one per way plus spare)
DEPTH, 512, number of indices; any value >= 2, not limited to a power of two
IDX_W, 9, index width; must satisfy 2^IDX_W >= DEPTH
INIT_ON_RESET, 1, 1 = sweep-clear after reset; 0 = leave contents undefined, start in IDLE

Ports:
forever_cpuclk  in  1  free-running core clock
cpurst_b  in  1  synchronous active-low reset
pad_yy_icg_scan_en  in  1  scan enable for the internal gated_clk_cell
cp0_lsu_icg_en  in  1  module clock-gate enable for the internal gated_clk_cell
dirty_gateclk_en  in  1  local clock enable from the requester
dirty_sel_b  in  1  access select, active low
dirty_gwen_b  in  1  0 = write, 1 = read
dirty_wen_b  in  WIDTH  per-bit write enable, active low
dirty_din  in  WIDTH  write data
dirty_idx  in  IDX_W  access index
dirty_clr_req  in  1  single-cycle pulse: clear the whole array
dirty_dout  out  WIDTH  registered read data
dirty_rd_vld  out  1  pulse: dirty_dout updated this cycle
dirty_busy  out  1  sweep in progress; accesses ignored
dirty_clr_done  out  1  single-cycle pulse on the last sweep write

Behaviour:
- Clocking: internal gated clock, local_en = dirty_gateclk_en | dirty_busy | dirty_clr_req | ~cpurst_b. The clock runs during reset so that the synchronous reset takes effect.
- Reset (cpurst_b=0 at an edge):
  - Outputs reset to dirty_dout=0, dirty_rd_vld=0, dirty_clr_done=0.
  - The sweep pointer resets to 0.
  - Next state is INIT when INIT_ON_RESET=1, otherwise IDLE. dirty_busy is 1 in INIT.
- FSM states: IDLE, INIT.
  - IDLE -> INIT when dirty_clr_req=1.
  - INIT -> IDLE after the cycle that writes index DEPTH-1.
  - An INIT sweep writes all-zero to index ptr each cycle, then increments ptr. Sweep length is exactly DEPTH cycles.
  - dirty_clr_done pulses in the cycle after the last write, together with dirty_busy falling.
- dirty_clr_req handling:
  - Ignored while in INIT; the sweep is not restarted.
  - If it arrives in the same cycle as an IDLE access, the access is performed first, then the sweep starts next cycle.
  - Reset during a sweep aborts it: ptr returns to 0 and the sweep restarts per INIT_ON_RESET. No clr_done pulse is produced for the aborted sweep.
- Access (IDLE only, dirty_sel_b=0):
  - Write (dirty_gwen_b=0): mem[idx][i] <= dirty_din[i] only for bits with dirty_wen_b[i]=0. dirty_dout is unchanged and dirty_rd_vld=0.
  - Read (dirty_gwen_b=1): dirty_dout <= mem[idx] at the next edge, so latency is 1 cycle. dirty_rd_vld=1 for that one cycle.
  - dirty_dout holds its value until the next read or reset.
  - Back-to-back reads give one result per cycle.
  - A read in the cycle after a write to the same index returns the newly written data.
- Busy: any access issued while dirty_busy=1 is dropped. No write occurs and no rd_vld is produced. The requester must hold off.
- Out-of-range idx (>= DEPTH): a write is dropped; a read returns 0 with rd_vld=1.
- dirty_sel_b=1: no state change; the gwen/wen/din/idx inputs are don't-care.

Test Plan:
- Reset with INIT_ON_RESET=1, DEPTH=512 -> dirty_busy=1 for exactly 512 cycles, clr_done pulses once, then reading index 37 gives dout=7'h00 with rd_vld one cycle after the read.
- Masked write: write din=7'h7F, wen_b=7'h00 to idx 5; then write din=7'h00, wen_b=7'h7C to idx 5; read idx 5 -> dout=7'h7C.
- Flush: fill indices 0..3 with 7'h55, pulse dirty_clr_req -> busy=1 for 512 cycles; a write attempted mid-sweep is dropped; after clr_done, reads of 0..3 return 7'h00.
- Reset mid-sweep at cycle 100 -> ptr restarts, busy stays high a further 512 cycles, exactly one clr_done pulse.
- Configuration DEPTH=200, IDX_W=8 -> sweep takes 200 cycles; read of idx 250 gives dout=0 with rd_vld=1; write to idx 250 leaves contents unchanged.
- Back-to-back reads of idx 1, 2, 3 (preloaded 7'h01/02/03) -> dout sequence 01, 02, 03 on consecutive cycles, rd_vld high for 3 cycles; dout holds 03 afterwards.

Source files
------------

// File: rtl/ct_lsu_dcache_dirty_array_pcfg.sv
// Purpose: parametrised dcache dirty-bit array with a bit-masked write, a registered read and a hardware clear sweep.
// Latency: read data and rd_vld appear one cycle after the access; a clear sweep takes DEPTH cycles.
// Backpressure: none; while dirty_busy=1 every access is dropped, so the requester must hold off.
//
// Ports:
//   forever_cpuclk / cpurst_b                 : free-running clock, synchronous active-low reset
//   pad_yy_icg_scan_en / cp0_lsu_icg_en       : clock-gate overrides (scan, module-level force-on)
//   dirty_gateclk_en                          : local clock enable from the requester
//   dirty_sel_b / dirty_gwen_b                : select (active low), 0 = write / 1 = read
//   dirty_wen_b / dirty_din / dirty_idx       : per-bit write enable (active low), write data, index
//   dirty_clr_req                             : pulse requesting a clear of the whole array
//   dirty_dout / dirty_rd_vld                 : registered read data and its one-cycle strobe
//   dirty_busy / dirty_clr_done               : sweep in progress, pulse after the final sweep write
module ct_lsu_dcache_dirty_array_pcfg #(
    parameter int WIDTH         = 7,
    parameter int DEPTH         = 512,
    parameter int IDX_W         = 9,
    parameter int INIT_ON_RESET = 1
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             pad_yy_icg_scan_en,
    input  logic             cp0_lsu_icg_en,
    input  logic             dirty_gateclk_en,
    input  logic             dirty_sel_b,
    input  logic             dirty_gwen_b,
    input  logic [WIDTH-1:0] dirty_wen_b,
    input  logic [WIDTH-1:0] dirty_din,
    input  logic [IDX_W-1:0] dirty_idx,
    input  logic             dirty_clr_req,
    output logic [WIDTH-1:0] dirty_dout,
    output logic             dirty_rd_vld,
    output logic             dirty_busy,
    output logic             dirty_clr_done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_INIT = 1'b1
    } state_t;

    // One extra bit so DEPTH == 2^IDX_W is representable in the range compare.
    localparam logic [IDX_W:0]   DEPTH_L  = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_dout;
    logic             r_rd_vld;
    logic             r_clr_done;

    logic             w_local_en;
    logic             w_clk_en;
    logic             w_idle;
    logic             w_acc;
    logic             w_in_range;
    logic             w_rd;
    logic             w_wr;
    logic             w_last;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_widx;
    logic [WIDTH-1:0] w_mem_wdat;

    // Clock gate modelled as a synchronous enable on every flop. The reset
    // term keeps the clock alive so the synchronous reset always lands; scan
    // and the module-level enable force the clock on, as in the gate cell.
    assign w_local_en = dirty_gateclk_en | dirty_busy | dirty_clr_req | ~cpurst_b;
    assign w_clk_en   = w_local_en | cp0_lsu_icg_en | pad_yy_icg_scan_en;

    assign w_idle     = (r_state == S_IDLE);
    assign w_acc      = w_clk_en & cpurst_b & w_idle & ~dirty_sel_b;
    assign w_in_range = ({1'b0, dirty_idx} < DEPTH_L);
    // Out-of-range reads still strobe rd_vld (and return zero); out-of-range writes are dropped.
    assign w_rd       = w_acc & dirty_gwen_b;
    assign w_wr       = w_acc & ~dirty_gwen_b & w_in_range;
    assign w_last     = (r_ptr == LAST_IDX);

    // Next-state logic. A clear request in IDLE only moves the FSM; any access
    // in that same cycle still completes because w_acc looks at the current state.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (dirty_clr_req) begin
                    w_state_nxt = S_INIT;
                    w_ptr_nxt   = '0;
                end
            end
            S_INIT: begin
                if (w_last) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                end else begin
                    w_ptr_nxt   = r_ptr + IDX_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Single write port shared between the sweep and requester writes; the
    // two are mutually exclusive by FSM state.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_widx = dirty_idx;
        w_mem_wdat = (r_mem[dirty_idx] & dirty_wen_b) | (dirty_din & ~dirty_wen_b);
        if (w_clk_en && cpurst_b) begin
            if (!w_idle) begin
                w_mem_we   = 1'b1;
                w_mem_widx = r_ptr;
                w_mem_wdat = '0;
            end else if (w_wr) begin
                w_mem_we   = 1'b1;
            end
        end
    end

    // Array contents are not reset; only the sweep clears them.
    always_ff @(posedge forever_cpuclk) begin
        if (w_mem_we) begin
            r_mem[w_mem_widx] <= w_mem_wdat;
        end
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state    <= (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;
            r_ptr      <= '0;
            r_dout     <= '0;
            r_rd_vld   <= 1'b0;
            r_clr_done <= 1'b0;
        end else if (w_clk_en) begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rd_vld   <= w_rd;
            // Set on the edge that performs the final sweep write, so the
            // pulse coincides with busy falling.
            r_clr_done <= ~w_idle & w_last;
            if (w_rd) begin
                r_dout <= w_in_range ? r_mem[dirty_idx] : '0;
            end
        end
    end

    assign dirty_dout     = r_dout;
    assign dirty_rd_vld   = r_rd_vld;
    assign dirty_busy     = (r_state == S_INIT);
    assign dirty_clr_done = r_clr_done;

endmodule
